// File: rtl/vebpf_call_client.sv
// vebpf_call_client: host-side initiator for the vEBPF core-request port.
// Queues helper calls, issues them one at a time to vebpf_scheduler, waits
// for r0 with a timeout and hands the result back over a valid/ready port.
// Optional build macro: VEBPF_CALL_STATS_EN adds call/timeout/latency counters.
module vebpf_call_client #(
    parameter int FUNCTION_ID_WIDTH = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         call_valid,
    output logic                         call_ready,
    input  logic [FUNCTION_ID_WIDTH-1:0] call_fid,
    input  logic [63:0]                  call_r1,
    input  logic [63:0]                  call_r2,
    input  logic [63:0]                  call_r3,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [FUNCTION_ID_WIDTH-1:0] res_fid,
    output logic [63:0]                  res_r0,
    output logic                         res_timeout,
    output logic [FUNCTION_ID_WIDTH-1:0] vebpf_core_req,
    output logic                         vebpf_request,
    output logic [63:0]                  vebpf_r1,
    output logic [63:0]                  vebpf_r2,
    output logic [63:0]                  vebpf_r3,
    input  logic [63:0]                  vebpf_r0,
    input  logic                         vebpf_r0_valid,
    input  logic                         vebpf_core_resp
`ifdef VEBPF_CALL_STATS_EN
    ,
    output logic [31:0]                  stat_calls,
    output logic [15:0]                  stat_timeouts,
    output logic [15:0]                  stat_max_lat
`endif
);

    localparam int ENTRY_W = FUNCTION_ID_WIDTH + 192;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state_reg, state_next;

    logic [ENTRY_W-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]             occ_reg;

    logic [FUNCTION_ID_WIDTH-1:0] core_req_reg;
    logic [63:0]                  r1_reg, r2_reg, r3_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [FUNCTION_ID_WIDTH-1:0] res_fid_reg;
    logic [63:0]                  res_r0_reg;
    logic                         res_timeout_reg;
    // Scheduler response flag is kept for observability only.
    logic                         resp_flag_unused_reg;

    logic push, pop, capture, timeout_hit;

    assign call_ready  = (occ_reg != OCC_W'(FIFO_DEPTH));
    assign push        = call_valid && call_ready;
    assign pop         = (state_reg == ST_IDLE) && (occ_reg != '0);
    assign capture     = (state_reg == ST_WAIT) && vebpf_r0_valid;
    // A response on the final WAIT cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == ST_WAIT) && !vebpf_r0_valid &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    assign vebpf_request  = (state_reg == ST_ISSUE);
    assign res_valid      = (state_reg == ST_HOLD);
    assign vebpf_core_req = core_req_reg;
    assign vebpf_r1       = r1_reg;
    assign vebpf_r2       = r2_reg;
    assign vebpf_r3       = r3_reg;
    assign res_fid        = res_fid_reg;
    assign res_r0         = res_r0_reg;
    assign res_timeout    = res_timeout_reg;

    // Call queue storage; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {call_fid, call_r1, call_r2, call_r3};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Call FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: one outstanding call at a time.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (occ_reg != '0) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (vebpf_r0_valid || timeout_hit) state_next = ST_HOLD;
            ST_HOLD:  if (res_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request/response datapath: head load (registered RAM read), timeout count, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_req_reg         <= '0;
            r1_reg               <= '0;
            r2_reg               <= '0;
            r3_reg               <= '0;
            cnt_reg              <= '0;
            res_fid_reg          <= '0;
            res_r0_reg           <= '0;
            res_timeout_reg      <= 1'b0;
            resp_flag_unused_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        {core_req_reg, r1_reg, r2_reg, r3_reg} <= fifo_mem[rd_ptr_reg];
                    end
                end
                ST_ISSUE: cnt_reg <= '0;
                ST_WAIT: begin
                    if (capture) begin
                        res_fid_reg          <= core_req_reg;
                        res_r0_reg           <= vebpf_r0;
                        res_timeout_reg      <= 1'b0;
                        resp_flag_unused_reg <= vebpf_core_resp;
                    end else if (timeout_hit) begin
                        res_fid_reg     <= core_req_reg;
                        res_r0_reg      <= 64'hFFFF_FFFF_FFFF_FFFF;
                        res_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VEBPF_CALL_STATS_EN
    logic [31:0] stat_calls_reg;
    logic [15:0] stat_timeouts_reg;
    logic [15:0] stat_max_lat_reg;
    logic [31:0] lat_raw;
    logic [15:0] lat_sat;

    // Latency counts cycles from the request pulse to the response cycle.
    assign lat_raw = 32'(cnt_reg) + 32'd1;
    assign lat_sat = (lat_raw > 32'd65535) ? 16'hFFFF : lat_raw[15:0];

    assign stat_calls    = stat_calls_reg;
    assign stat_timeouts = stat_timeouts_reg;
    assign stat_max_lat  = stat_max_lat_reg;

    // Call statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_calls_reg    <= '0;
            stat_timeouts_reg <= '0;
            stat_max_lat_reg  <= '0;
        end else begin
            if (state_reg == ST_ISSUE) stat_calls_reg <= stat_calls_reg + 32'd1;
            if (timeout_hit && (stat_timeouts_reg != 16'hFFFF))
                stat_timeouts_reg <= stat_timeouts_reg + 16'd1;
            if (capture && (lat_sat > stat_max_lat_reg))
                stat_max_lat_reg <= lat_sat;
        end
    end
`endif

endmodule

// File: tb/tb_vebpf_call_client.sv
// tb_vebpf_call_client: directed bench for vebpf_call_client with a
// behavioural scheduler responder (r0 = r1 << 2 after a programmable delay).
module tb_vebpf_call_client;

    localparam int FW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          call_valid;
    logic          call_ready;
    logic [FW-1:0] call_fid;
    logic [63:0]   call_r1, call_r2, call_r3;
    logic          res_valid;
    logic          res_ready;
    logic [FW-1:0] res_fid;
    logic [63:0]   res_r0;
    logic          res_timeout;
    logic [FW-1:0] vebpf_core_req;
    logic          vebpf_request;
    logic [63:0]   vebpf_r1, vebpf_r2, vebpf_r3;
    logic [63:0]   vebpf_r0;
    logic          vebpf_r0_valid;
    logic          vebpf_core_resp;
`ifdef VEBPF_CALL_STATS_EN
    logic [31:0]   stat_calls;
    logic [15:0]   stat_timeouts;
    logic [15:0]   stat_max_lat;
`endif

    vebpf_call_client #(
        .FUNCTION_ID_WIDTH (FW),
        .FIFO_DEPTH        (DEPTH),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .call_valid      (call_valid),
        .call_ready      (call_ready),
        .call_fid        (call_fid),
        .call_r1         (call_r1),
        .call_r2         (call_r2),
        .call_r3         (call_r3),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_fid         (res_fid),
        .res_r0          (res_r0),
        .res_timeout     (res_timeout),
        .vebpf_core_req  (vebpf_core_req),
        .vebpf_request   (vebpf_request),
        .vebpf_r1        (vebpf_r1),
        .vebpf_r2        (vebpf_r2),
        .vebpf_r3        (vebpf_r3),
        .vebpf_r0        (vebpf_r0),
        .vebpf_r0_valid  (vebpf_r0_valid),
        .vebpf_core_resp (vebpf_core_resp)
`ifdef VEBPF_CALL_STATS_EN
        ,
        .stat_calls      (stat_calls),
        .stat_timeouts   (stat_timeouts),
        .stat_max_lat    (stat_max_lat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: answers each request pulse after resp_delay cycles.
    int          resp_delay = 3;
    int          pulse_count = 0;
    int          last_pulse_cyc = 0;
    logic [FW-1:0] last_pulse_fid = '0;
    logic [63:0] last_pulse_r1 = '0;

    initial begin
        int d;
        logic [63:0] rv;
        vebpf_r0_valid  = 1'b0;
        vebpf_r0        = '0;
        vebpf_core_resp = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (vebpf_request === 1'b1) begin
                pulse_count++;
                last_pulse_cyc = cyc;
                last_pulse_fid = vebpf_core_req;
                last_pulse_r1  = vebpf_r1;
                d  = resp_delay;
                rv = vebpf_r1 << 2;
                repeat (d) begin @(posedge clk); #1; end
                vebpf_r0_valid  = 1'b1;
                vebpf_r0        = rv;
                vebpf_core_resp = 1'b1;
                @(posedge clk); #1;
                vebpf_r0_valid  = 1'b0;
                vebpf_r0        = '0;
                vebpf_core_resp = 1'b0;
            end
        end
    end

    // Request pulse width monitor.
    int req_run = 0;
    int req_max_run = 0;
    always @(negedge clk) begin
        if (vebpf_request === 1'b1) begin
            req_run++;
            if (req_run > req_max_run) req_max_run = req_run;
        end else begin
            req_run = 0;
        end
    end

    // Result monitor: records every completed handshake.
    logic [FW-1:0] q_fid [$];
    logic [63:0]   q_r0  [$];
    logic          q_to  [$];
    int            q_cyc [$];
    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            q_fid.push_back(res_fid);
            q_r0.push_back(res_r0);
            q_to.push_back(res_timeout);
            q_cyc.push_back(cyc);
            $display("result: fid=%0h r0=%0h timeout=%0b cycle=%0d", res_fid, res_r0, res_timeout, cyc);
        end
    end

    task automatic push_call(input logic [FW-1:0] fid, input logic [63:0] r1, output int acc_cyc);
        bit done = 0;
        call_fid   = fid;
        call_r1    = r1;
        call_r2    = 64'h2222;
        call_r3    = 64'h3333;
        call_valid = 1'b1;
        acc_cyc    = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (call_ready) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        call_valid = 1'b0;
        if (!done) check_eq("push_accept", call_ready, 1);
        $display("push: fid=%0h r1=%0h accepted_cycle=%0d", fid, r1, acc_cyc);
    endtask

    task automatic wait_results(input int n, input int bound);
        for (int i = 0; i < bound && q_fid.size() < n; i++) begin
            @(posedge clk); #1;
        end
        if (q_fid.size() < n) check_eq("result_wait", q_fid.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_call_ready"},  call_ready, 1);
        check_eq({tag, "_res_valid"},   res_valid, 0);
        check_eq({tag, "_request"},     vebpf_request, 0);
        check_eq({tag, "_core_req"},    vebpf_core_req, 0);
        check_eq({tag, "_r1"},          vebpf_r1, 0);
        check_eq({tag, "_r2"},          vebpf_r2, 0);
        check_eq({tag, "_r3"},          vebpf_r3, 0);
        check_eq({tag, "_res_fid"},     res_fid, 0);
        check_eq({tag, "_res_r0"},      res_r0, 0);
        check_eq({tag, "_res_timeout"}, res_timeout, 0);
    endtask

    // Completes one call and checks its result against the responder model.
    task automatic single_call(input string tag, input logic [FW-1:0] fid, input logic [63:0] r1,
                               input int delay, input bit exp_to);
        int acc;
        int n0;
        n0 = q_fid.size();
        resp_delay = delay;
        push_call(fid, r1, acc);
        wait_results(n0 + 1, 100);
        check_eq({tag, "_fid"},     q_fid[n0], fid);
        check_eq({tag, "_timeout"}, q_to[n0], exp_to);
        check_eq({tag, "_r0"},      q_r0[n0], exp_to ? 64'hFFFF_FFFF_FFFF_FFFF : (r1 << 2));
        check_eq({tag, "_latency"}, q_cyc[n0] - last_pulse_cyc, exp_to ? TMO + 1 : delay + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;
        int p0;
        rst        = 1'b1;
        call_valid = 1'b0;
        call_fid   = '0;
        call_r1    = '0;
        call_r2    = '0;
        call_r3    = '0;
        res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef VEBPF_CALL_STATS_EN
        check_eq("reset_stat_calls", stat_calls, 0);
        check_eq("reset_stat_timeouts", stat_timeouts, 0);
        check_eq("reset_stat_max_lat", stat_max_lat, 0);
`endif
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single call: pulse one edge after acceptance, r0 three cycles after pulse.
        resp_delay = 3;
        p0 = pulse_count;
        call_fid = 8'h01; call_r1 = 64'h4; call_r2 = 64'h2222; call_r3 = 64'h3333;
        push_call(8'h01, 64'h4, acc);
        wait_results(1, 50);
        check_eq("single_pulses", pulse_count - p0, 1);
        check_eq("single_issue_cycle", last_pulse_cyc, acc + 1);
        check_eq("single_core_req", last_pulse_fid, 8'h01);
        check_eq("single_vebpf_r1", last_pulse_r1, 64'h4);
        check_eq("single_fid", q_fid[0], 8'h01);
        check_eq("single_r0", q_r0[0], 64'h10);
        check_eq("single_timeout", q_to[0], 0);
        check_eq("single_latency", q_cyc[0] - last_pulse_cyc, 4);

        // Queue fill: host stalls results; 1 in flight + 4 queued blocks the 6th.
        repeat (3) begin @(posedge clk); #1; end
        base = q_fid.size();
        res_ready = 1'b0;
        for (int f = 2; f <= 6; f++) push_call(FW'(f), 64'(f * 16), acc);
        repeat (6) begin @(posedge clk); #1; end
        check_eq("fill_call_ready", call_ready, 0);
        check_eq("fill_res_valid", res_valid, 1);
        check_eq("fill_no_results", q_fid.size(), base);
        res_ready = 1'b1;
        push_call(8'h07, 64'(7 * 16), acc);
        wait_results(base + 6, 300);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("fill_order_%0d", k), q_fid[base + k], 64'(k + 2));
            check_eq($sformatf("fill_r0_%0d", k), q_r0[base + k], 64'((k + 2) * 64));
        end

        // Timeout: no answer within TMO WAIT cycles; late answer dropped.
        repeat (3) begin @(posedge clk); #1; end
        single_call("tmo", 8'h08, 64'h5, TMO + 4, 1'b1);
        base = q_fid.size();
        repeat (10) begin @(posedge clk); #1; end
        check_eq("tmo_late_dropped", q_fid.size(), base);
        single_call("after_tmo", 8'h09, 64'h6, 5, 1'b0);

        // Boundary: answer on the final WAIT cycle wins; one cycle later times out.
        repeat (3) begin @(posedge clk); #1; end
        single_call("edge_win", 8'h0A, 64'h77, TMO, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        single_call("edge_lose", 8'h0B, 64'h78, TMO + 1, 1'b1);
        repeat (6) begin @(posedge clk); #1; end

        // Reset while waiting: call abandoned, later response ignored.
        resp_delay = 8;
        p0 = pulse_count;
        base = q_fid.size();
        push_call(8'h0C, 64'h99, acc);
        for (int i = 0; i < 10 && pulse_count == p0; i++) begin @(posedge clk); #1; end
        check_eq("rst_pulse_seen", pulse_count - p0, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("rst_wait");
        repeat (12) begin @(posedge clk); #1; end
        check_eq("rst_no_result", q_fid.size(), base);
        check_eq("rst_res_valid", res_valid, 0);

        // Statistics scenario after a fresh reset: latencies 2, 7, 4 then one timeout.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        single_call("stat_a", 8'h10, 64'h1, 2, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        single_call("stat_b", 8'h11, 64'h2, 7, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        single_call("stat_c", 8'h12, 64'h3, 4, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        single_call("stat_d", 8'h13, 64'h4, TMO + 4, 1'b1);
        repeat (8) begin @(posedge clk); #1; end
`ifdef VEBPF_CALL_STATS_EN
        check_eq("stat_calls", stat_calls, 4);
        check_eq("stat_timeouts", stat_timeouts, 1);
        check_eq("stat_max_lat", stat_max_lat, 7);
`endif

        check_eq("req_pulse_width", req_max_run, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
